// File: rtl/dual_port_ram_be.sv
// Dual-port RAM with per-lane write enables on both ports.
// Port A wins on lanes both ports write at the same address in the same cycle.
// Reads have a selectable latency of 1 or 2 registered stages, fully pipelined.
module dual_port_ram_be #(
    parameter int WIDTH      = 12,
    parameter int ADDR_WIDTH = 10,
    parameter int LANE_WIDTH = 4,
    parameter int RD_LATENCY = 1,
    parameter int WRITE_MODE = 0
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_en_a,
    input  logic [WIDTH/LANE_WIDTH-1:0]   i_we_a,
    input  logic [ADDR_WIDTH-1:0]         i_addr_a,
    input  logic [WIDTH-1:0]              i_din_a,
    output logic [WIDTH-1:0]              o_dout_a,
    output logic                          o_valid_a,
    input  logic                          i_en_b,
    input  logic [WIDTH/LANE_WIDTH-1:0]   i_we_b,
    input  logic [ADDR_WIDTH-1:0]         i_addr_b,
    input  logic [WIDTH-1:0]              i_din_b,
    output logic [WIDTH-1:0]              o_dout_b,
    output logic                          o_valid_b,
    output logic                          o_collision
);

    localparam int LANES = WIDTH / LANE_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Elaboration-time parameter checks
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("dual_port_ram_be: RD_LATENCY must be 1 or 2");
    end
    if (WIDTH % LANE_WIDTH != 0) begin : g_bad_lanes
        $error("dual_port_ram_be: WIDTH must be a multiple of LANE_WIDTH");
    end
    if (WRITE_MODE != 0 && WRITE_MODE != 1) begin : g_bad_mode
        $error("dual_port_ram_be: WRITE_MODE must be 0 or 1");
    end

    // Replace the lanes selected by we with the matching lanes of din
    function automatic logic [WIDTH-1:0] lane_merge(
        input logic [WIDTH-1:0] old_word,
        input logic [WIDTH-1:0] din,
        input logic [LANES-1:0] we
    );
        logic [WIDTH-1:0] res;
        res = old_word;
        for (int k = 0; k < LANES; k++) begin
            if (we[k]) begin
                res[k*LANE_WIDTH +: LANE_WIDTH] = din[k*LANE_WIDTH +: LANE_WIDTH];
            end
        end
        return res;
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];

    logic             wr_a;
    logic             wr_b;
    logic             same_addr;
    logic [WIDTH-1:0] old_a;
    logic [WIDTH-1:0] old_b;
    logic [WIDTH-1:0] merged_a;
    logic [WIDTH-1:0] merged_b;
    logic [WIDTH-1:0] store_a;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;
    logic             coll_d;

    // Write decode, lane merging and read-data selection
    always_comb begin
        wr_a      = i_en_a && (|i_we_a);
        wr_b      = i_en_b && (|i_we_b);
        same_addr = (i_addr_a == i_addr_b);
        old_a     = mem[i_addr_a];
        old_b     = mem[i_addr_b];
        merged_a  = lane_merge(old_a, i_din_a, i_we_a);
        merged_b  = lane_merge(old_b, i_din_b, i_we_b);
        // On a shared-address double write, A's lanes are laid over B's merged word
        // so B-only lanes survive and overlapping lanes take A's data.
        store_a   = (wr_b && same_addr) ? lane_merge(merged_b, i_din_a, i_we_a) : merged_a;
        // Write-first returns the port's own merged word; the other port's
        // write is never visible in the same cycle.
        rd_a      = (WRITE_MODE == 1 && wr_a) ? merged_a : old_a;
        rd_b      = (WRITE_MODE == 1 && wr_b) ? merged_b : old_b;
        coll_d    = wr_a && wr_b && same_addr && (|(i_we_a & i_we_b));
    end

    // Array update; A is written last so it overrides B on a shared address
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (wr_b) begin
                mem[i_addr_b] <= merged_b;
            end
            if (wr_a) begin
                mem[i_addr_a] <= store_a;
            end
        end
    end

    logic             v1_a;
    logic             v1_b;
    logic [WIDTH-1:0] d1_a;
    logic [WIDTH-1:0] d1_b;
    logic             coll_q;

    // First read stage; data only moves on an access so idle ports hold
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v1_a   <= 1'b0;
            v1_b   <= 1'b0;
            d1_a   <= '0;
            d1_b   <= '0;
            coll_q <= 1'b0;
        end else begin
            v1_a   <= i_en_a;
            v1_b   <= i_en_b;
            coll_q <= coll_d;
            if (i_en_a) begin
                d1_a <= rd_a;
            end
            if (i_en_b) begin
                d1_b <= rd_b;
            end
        end
    end

    assign o_collision = coll_q;

    if (RD_LATENCY == 2) begin : g_lat2
        logic             v2_a;
        logic             v2_b;
        logic [WIDTH-1:0] d2_a;
        logic [WIDTH-1:0] d2_b;

        // Second read stage, advanced by stage-one valid to keep holds intact
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                v2_a <= 1'b0;
                v2_b <= 1'b0;
                d2_a <= '0;
                d2_b <= '0;
            end else begin
                v2_a <= v1_a;
                v2_b <= v1_b;
                if (v1_a) begin
                    d2_a <= d1_a;
                end
                if (v1_b) begin
                    d2_b <= d1_b;
                end
            end
        end

        assign o_valid_a = v2_a;
        assign o_valid_b = v2_b;
        assign o_dout_a  = d2_a;
        assign o_dout_b  = d2_b;
    end else begin : g_lat1
        assign o_valid_a = v1_a;
        assign o_valid_b = v1_b;
        assign o_dout_a  = d1_a;
        assign o_dout_b  = d1_b;
    end

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Directed bench: two DUTs share stimulus; d1 is latency 1 / read-first,
// d2 is latency 2 / write-first.
module tb_dual_port_ram_be;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, en_b;
    logic [2:0]  we_a, we_b;
    logic [9:0]  addr_a, addr_b;
    logic [11:0] din_a, din_b;

    logic [11:0] d1_dout_a, d1_dout_b, d2_dout_a, d2_dout_b;
    logic        d1_valid_a, d1_valid_b, d2_valid_a, d2_valid_b;
    logic        d1_coll, d2_coll;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dual_port_ram_be #(.RD_LATENCY(1), .WRITE_MODE(0)) d1 (
        .i_clk(clk), .i_rst(rst),
        .i_en_a(en_a), .i_we_a(we_a), .i_addr_a(addr_a), .i_din_a(din_a),
        .o_dout_a(d1_dout_a), .o_valid_a(d1_valid_a),
        .i_en_b(en_b), .i_we_b(we_b), .i_addr_b(addr_b), .i_din_b(din_b),
        .o_dout_b(d1_dout_b), .o_valid_b(d1_valid_b),
        .o_collision(d1_coll)
    );

    dual_port_ram_be #(.RD_LATENCY(2), .WRITE_MODE(1)) d2 (
        .i_clk(clk), .i_rst(rst),
        .i_en_a(en_a), .i_we_a(we_a), .i_addr_a(addr_a), .i_din_a(din_a),
        .o_dout_a(d2_dout_a), .o_valid_a(d2_valid_a),
        .i_en_b(en_b), .i_we_b(we_b), .i_addr_b(addr_b), .i_din_b(din_b),
        .o_dout_b(d2_dout_b), .o_valid_b(d2_valid_b),
        .o_collision(d2_coll)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic e, input logic [2:0] w, input logic [9:0] a,
                         input logic [11:0] d);
        en_a = e; we_a = w; addr_a = a; din_a = d;
    endtask

    task automatic set_b(input logic e, input logic [2:0] w, input logic [9:0] a,
                         input logic [11:0] d);
        en_b = e; we_b = w; addr_b = a; din_b = d;
    endtask

    task automatic idle();
        set_a(1'b0, 3'b000, 10'd0, 12'h000);
        set_b(1'b0, 3'b000, 10'd0, 12'h000);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        n_checks++;
        if ({d1_dout_a, d1_dout_b} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_d1_dout got %h/%h want 000/000", d1_dout_a, d1_dout_b);
        end
        n_checks++;
        if ({d2_dout_a, d2_dout_b} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_d2_dout got %h/%h want 000/000", d2_dout_a, d2_dout_b);
        end
        n_checks++;
        if ({d1_valid_a, d1_valid_b, d2_valid_a, d2_valid_b, d1_coll, d2_coll} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags got %b%b%b%b%b%b want 000000", d1_valid_a, d1_valid_b,
                     d2_valid_a, d2_valid_b, d1_coll, d2_coll);
        end
        rst = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({d1_valid_a, d2_valid_a} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_valid got %b%b want 00", d1_valid_a, d2_valid_a);
        end
    endtask

    task automatic test_lane_mask();
        set_a(1'b1, 3'b111, 10'd5, 12'hABC);
        tick();
        set_a(1'b1, 3'b010, 10'd5, 12'h123);
        tick();
        set_a(1'b1, 3'b000, 10'd5, 12'h000);
        tick();
        idle();
        n_checks++;
        if (d1_dout_a !== 12'hA2C || d1_valid_a !== 1'b1) begin
            n_fail++;
            $display("FAIL lane_mask_d1 got %h v%b want a2c v1", d1_dout_a, d1_valid_a);
        end
        tick();
        n_checks++;
        if (d2_dout_a !== 12'hA2C || d2_valid_a !== 1'b1) begin
            n_fail++;
            $display("FAIL lane_mask_d2 got %h v%b want a2c v1", d2_dout_a, d2_valid_a);
        end
        n_checks++;
        if (d1_dout_a !== 12'hA2C || d1_valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_d1 got %h v%b want a2c v0", d1_dout_a, d1_valid_a);
        end
        tick();
        n_checks++;
        if (d2_dout_a !== 12'hA2C || d2_valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_d2 got %h v%b want a2c v0", d2_dout_a, d2_valid_a);
        end
    endtask

    task automatic test_collision();
        set_a(1'b1, 3'b111, 10'd9, 12'h111);
        set_b(1'b1, 3'b111, 10'd9, 12'h222);
        tick();
        idle();
        n_checks++;
        if ({d1_coll, d2_coll} !== 2'b11) begin
            n_fail++;
            $display("FAIL collision_full got %b%b want 11", d1_coll, d2_coll);
        end
        set_a(1'b1, 3'b000, 10'd9, 12'h000);
        tick();
        idle();
        n_checks++;
        if ({d1_coll, d2_coll} !== 2'b00) begin
            n_fail++;
            $display("FAIL collision_pulse got %b%b want 00", d1_coll, d2_coll);
        end
        n_checks++;
        if (d1_dout_a !== 12'h111) begin
            n_fail++;
            $display("FAIL collision_data_d1 got %h want 111", d1_dout_a);
        end
        tick();
        n_checks++;
        if (d2_dout_a !== 12'h111) begin
            n_fail++;
            $display("FAIL collision_data_d2 got %h want 111", d2_dout_a);
        end
        set_a(1'b1, 3'b001, 10'd9, 12'h111);
        set_b(1'b1, 3'b110, 10'd9, 12'h222);
        tick();
        idle();
        n_checks++;
        if ({d1_coll, d2_coll} !== 2'b00) begin
            n_fail++;
            $display("FAIL collision_disjoint got %b%b want 00", d1_coll, d2_coll);
        end
        set_b(1'b1, 3'b000, 10'd9, 12'h000);
        tick();
        idle();
        n_checks++;
        if (d1_dout_b !== 12'h221) begin
            n_fail++;
            $display("FAIL disjoint_data_d1 got %h want 221", d1_dout_b);
        end
        tick();
        n_checks++;
        if (d2_dout_b !== 12'h221) begin
            n_fail++;
            $display("FAIL disjoint_data_d2 got %h want 221", d2_dout_b);
        end
    endtask

    task automatic test_reset_mid_read();
        set_a(1'b1, 3'b000, 10'd5, 12'h000);
        tick();
        idle();
        rst = 1'b1;
        tick();
        n_checks++;
        if (d2_valid_a !== 1'b0 || d2_dout_a !== 12'h000 || d1_dout_a !== 12'h000) begin
            n_fail++;
            $display("FAIL mid_reset got d2 %h v%b d1 %h want 000 v0 000", d2_dout_a,
                     d2_valid_a, d1_dout_a);
        end
        // Accesses while in reset must be dropped entirely
        set_a(1'b1, 3'b111, 10'd5, 12'h777);
        set_b(1'b1, 3'b111, 10'd9, 12'h777);
        tick();
        idle();
        rst = 1'b0;
        tick();
        n_checks++;
        if ({d1_valid_a, d1_valid_b, d2_valid_a, d2_valid_b} !== 4'b0) begin
            n_fail++;
            $display("FAIL post_reset_valid got %b%b%b%b want 0000", d1_valid_a, d1_valid_b,
                     d2_valid_a, d2_valid_b);
        end
        tick();
        n_checks++;
        if (d2_valid_a !== 1'b0 || d2_valid_b !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_valid2 got %b%b want 00", d2_valid_a, d2_valid_b);
        end
        set_a(1'b1, 3'b000, 10'd5, 12'h000);
        set_b(1'b1, 3'b000, 10'd9, 12'h000);
        tick();
        idle();
        tick();
        n_checks++;
        if (d2_dout_a !== 12'hA2C || d2_dout_b !== 12'h221 || d2_valid_a !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_keeps_data got %h/%h v%b want a2c/221 v1", d2_dout_a,
                     d2_dout_b, d2_valid_a);
        end
        n_checks++;
        if (d1_dout_a !== 12'hA2C || d1_dout_b !== 12'h221) begin
            n_fail++;
            $display("FAIL reset_keeps_data_d1 got %h/%h want a2c/221", d1_dout_a, d1_dout_b);
        end
    endtask

    task automatic test_read_during_write();
        set_a(1'b1, 3'b111, 10'd3, 12'h0F0);
        tick();
        set_a(1'b1, 3'b111, 10'd3, 12'hFFF);
        set_b(1'b1, 3'b000, 10'd3, 12'h000);
        tick();
        idle();
        n_checks++;
        if (d1_dout_a !== 12'h0F0 || d1_dout_b !== 12'h0F0) begin
            n_fail++;
            $display("FAIL rdw_read_first got %h/%h want 0f0/0f0", d1_dout_a, d1_dout_b);
        end
        tick();
        n_checks++;
        if (d2_dout_a !== 12'hFFF || d2_dout_b !== 12'h0F0) begin
            n_fail++;
            $display("FAIL rdw_write_first got %h/%h want fff/0f0", d2_dout_a, d2_dout_b);
        end
    endtask

    task automatic test_same_addr_read();
        set_a(1'b1, 3'b000, 10'd3, 12'h000);
        set_b(1'b1, 3'b000, 10'd3, 12'h000);
        tick();
        idle();
        n_checks++;
        if (d1_dout_a !== 12'hFFF || d1_dout_b !== 12'hFFF || d1_coll !== 1'b0) begin
            n_fail++;
            $display("FAIL dual_read_d1 got %h/%h c%b want fff/fff c0", d1_dout_a, d1_dout_b,
                     d1_coll);
        end
        tick();
        n_checks++;
        if (d2_dout_a !== 12'hFFF || d2_dout_b !== 12'hFFF || d2_valid_b !== 1'b1) begin
            n_fail++;
            $display("FAIL dual_read_d2 got %h/%h v%b want fff/fff v1", d2_dout_a, d2_dout_b,
                     d2_valid_b);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp;
        for (int i = 0; i < 8; i++) begin
            set_a(1'b1, 3'b111, 10'(i), 12'h800 + 12'(i * 17));
            tick();
        end
        idle();
        tick();
        tick();
        for (int k = 0; k < 10; k++) begin
            if (k < 8) set_a(1'b1, 3'b000, 10'(k), 12'h000);
            else idle();
            tick();
            exp = 12'h800 + 12'(k * 17);
            n_checks++;
            if (k < 8 && (d1_valid_a !== 1'b1 || d1_dout_a !== exp)) begin
                n_fail++;
                $display("FAIL pipe_d1 k=%0d got %h v%b want %h v1", k, d1_dout_a,
                         d1_valid_a, exp);
            end else if (k >= 8 && d1_valid_a !== 1'b0) begin
                n_fail++;
                $display("FAIL pipe_d1 k=%0d got v%b want v0", k, d1_valid_a);
            end
            exp = 12'h800 + 12'((k - 1) * 17);
            n_checks++;
            if (k >= 1 && k <= 8 && (d2_valid_a !== 1'b1 || d2_dout_a !== exp)) begin
                n_fail++;
                $display("FAIL pipe_d2 k=%0d got %h v%b want %h v1", k, d2_dout_a,
                         d2_valid_a, exp);
            end else if ((k == 0 || k == 9) && d2_valid_a !== 1'b0) begin
                n_fail++;
                $display("FAIL pipe_d2 k=%0d got v%b want v0", k, d2_valid_a);
            end
        end
    endtask

    task automatic test_boundary();
        set_b(1'b1, 3'b111, 10'd1023, 12'h5A5);
        tick();
        set_a(1'b1, 3'b000, 10'd1023, 12'h000);
        set_b(1'b1, 3'b000, 10'd0, 12'h000);
        tick();
        idle();
        n_checks++;
        if (d1_dout_a !== 12'h5A5 || d1_dout_b !== 12'h800) begin
            n_fail++;
            $display("FAIL boundary_d1 got %h/%h want 5a5/800", d1_dout_a, d1_dout_b);
        end
        tick();
        n_checks++;
        if (d2_dout_a !== 12'h5A5 || d2_dout_b !== 12'h800) begin
            n_fail++;
            $display("FAIL boundary_d2 got %h/%h want 5a5/800", d2_dout_a, d2_dout_b);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_lane_mask();
        test_collision();
        test_reset_mid_read();
        test_read_during_write();
        test_same_addr_read();
        test_back_to_back();
        test_boundary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dual_port_ram_be.md
DUAL_PORT_RAM_BE -- requirements
Module: dual_port_ram_be

Interface
REQ-001 The block SHALL run on one clock, and its reset SHALL be synchronous and active-high.
REQ-002 Parameter WIDTH, default 12: data word width in bits.
REQ-003 Parameter ADDR_WIDTH, default 10: address width; depth = 2**ADDR_WIDTH words.
REQ-004 Parameter LANE_WIDTH, default 4: write-enable granularity; WIDTH SHALL be an integer multiple of LANE_WIDTH; LANES = WIDTH/LANE_WIDTH.
REQ-005 Parameter RD_LATENCY, default 1: read latency in cycles; legal values 1 or 2; elaboration SHALL fail on any other value.
REQ-006 Parameter WRITE_MODE, default 0: same-port read-during-write; 0 = read-first (old data), 1 = write-first (new merged data).
REQ-007 i_clk  input  1  clock shared by both ports.
REQ-008 i_rst  input  1  synchronous active-high reset.
REQ-009 i_en_a / i_en_b  input  1  port access enable.
REQ-010 i_we_a / i_we_b  input  LANES  per-lane write enable; honoured only when the port's i_en is high; all-zero = read.
REQ-011 i_addr_a / i_addr_b  input  ADDR_WIDTH  word address.
REQ-012 i_din_a / i_din_b  input  WIDTH  write data; lane k = bits [k*LANE_WIDTH +: LANE_WIDTH].
REQ-013 o_dout_a / o_dout_b  output  WIDTH  read data.
REQ-014 o_valid_a / o_valid_b  output  1  o_dout of that port carries the result of an access issued RD_LATENCY cycles earlier.
REQ-015 o_collision  output  1  one-cycle pulse: both ports wrote overlapping lanes of the same address.

Function
REQ-016 Every cycle with i_en_x=1 SHALL be an access on port x; its result SHALL appear on o_dout_x with o_valid_x=1 exactly RD_LATENCY cycles later.
REQ-017 With RD_LATENCY=2, the second register stage SHALL be pipelined; back-to-back accesses SHALL produce back-to-back valid results with no bubbles.
REQ-018 A write SHALL update only the lanes whose i_we bit is 1; all other lanes of the word SHALL keep their contents.
REQ-019 Same-port read-during-write: WRITE_MODE=0 SHALL return the pre-write word; WRITE_MODE=1 SHALL return the post-write merged word.
REQ-020 Cross-port, same address, same cycle: a port that reads while the other port writes SHALL return the pre-write word, regardless of WRITE_MODE.
REQ-021 Both ports write the same address in the same cycle: for lanes enabled on both ports, port A data SHALL be stored; for lanes enabled on only one port, that port's data SHALL be stored.
REQ-022 o_collision SHALL assert in the cycle after such a write if at least one lane is enabled on both ports; disjoint lane masks to the same address SHALL NOT assert it.
REQ-023 Same-cycle reads of the same address on both ports SHALL both return identical data, with no collision.
REQ-024 With i_en_x=0, o_dout_x SHALL hold its last value and o_valid_x SHALL be 0 once the pipeline drains.
REQ-025 The address space SHALL be fully decoded; address 2**ADDR_WIDTH-1 SHALL be usable, and there is no wrap-around or out-of-range case.

Reset
REQ-026 While i_rst=1: o_dout_a=0, o_dout_b=0, o_valid_a=0, o_valid_b=0, o_collision=0, and all read-pipeline stages SHALL be cleared.
REQ-027 Accesses presented while i_rst=1 SHALL be ignored: no write to the array and no valid result afterwards.
REQ-028 Reset asserted mid-operation SHALL discard every in-flight read; no o_valid pulse from a pre-reset access SHALL appear after reset.
REQ-029 Reset SHALL NOT clear array contents; data written before reset SHALL be readable after reset.

Verification
REQ-030 Lane mask: A writes 0xABC to addr 5 with we=3'b111, then 0x123 with we=3'b010; A reads addr 5 -> o_dout_a=0xA2C, o_valid_a high RD_LATENCY cycles after the read.
REQ-031 Write collision: same cycle, A writes 0x111 and B writes 0x222 to addr 9, both with we=3'b111 -> next cycle o_collision=1; a later read of addr 9 returns 0x111. Repeat with A we=3'b001 and B we=3'b110 -> o_collision=0, read returns 0x221.
REQ-032 Read-during-write: addr 3 holds 0x0F0; A writes 0xFFF with we=3'b111 while B reads addr 3 -> o_dout_b=0x0F0; o_dout_a=0x0F0 when WRITE_MODE=0 and 0xFFF when WRITE_MODE=1.
REQ-033 Pipeline: RD_LATENCY=2, A reads addrs 0..7 on consecutive cycles -> eight consecutive o_valid_a cycles with the data in order, starting 2 cycles after the first read.
REQ-034 Reset mid-read: RD_LATENCY=2, read issued, then i_rst=1 on the following cycle -> no o_valid_a pulse, and o_dout_a=0 after the reset edge; a read after reset returns the pre-reset contents.
REQ-035 Boundary: write 0x5A5 to addr 1023 (ADDR_WIDTH=10) via B, read via A -> 0x5A5; addr 0 remains unchanged.
